// File: rtl/iir_out_decimator.sv
// Output stage behind the biquad IIR filter. It does boxcar decimation by
// R = 1/2/4/8, then round-half-up, an extra arithmetic shift and saturation to
// OUT_W bits. Results go into a small first-word-fall-through FIFO that has a
// valid/ready handshake toward the sink.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   en              block enable; low clears the accumulator and frame counter
//   dec_sel         decimation select (R = 1 << dec_sel), latched per frame
//   in_data/valid   signed filter samples; there is no backpressure
//   out_data/valid  FIFO head (registered) and FIFO-not-empty
//   out_ready       sink accepts the head when out_valid & out_ready
//   ovf, sat        sticky flags: sample dropped on full FIFO / sample clipped
//   clr_flags       synchronous clear of ovf and sat (a set in the same cycle wins)
//   fifo_level      current FIFO occupancy
module iir_out_decimator #(
    parameter int unsigned IN_W       = 32,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [1:0]                    dec_sel,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          ovf,
    output logic                          sat,
    input  logic                          clr_flags,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned ACC_W = IN_W + 3;
    localparam int unsigned RND_W = ACC_W + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned N_W   = 5;

    localparam logic signed [RND_W-1:0] SAT_MAX =
        $signed({{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [RND_W-1:0] SAT_MIN =
        $signed({{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

    // Accumulate-and-dump state
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [1:0]              k_q, k_d;

    // Stage 1: frame sum; stage 2: rounded and saturated sample
    logic signed [ACC_W-1:0] s1_q, s1_d;
    logic [1:0]              s1_k_q, s1_k_d;
    logic                    s1_vld_q, s1_vld_d;
    logic [OUT_W-1:0]        s2_q, s2_d;
    logic                    s2_vld_q, s2_vld_d;

    // FIFO
    logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0]        lvl_q, lvl_d;
    logic [OUT_W-1:0]        head_q, head_d;
    logic                    vld_q, vld_d;
    logic                    ovf_q, ovf_d, sat_q, sat_d;

    // Combinational intermediates
    logic                    accept, last, clip_hi, clip_lo, pop, full, push_ok, drop;
    logic [1:0]              k_eff;
    logic signed [ACC_W-1:0] in_sx, sum;
    logic [N_W-1:0]          n;
    logic [RND_W-1:0]        rnd_add;
    logic signed [RND_W-1:0] rnd, shifted;
    logic [OUT_W-1:0]        sat_val;

    // Next-state logic for the datapath, FIFO and flags
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        s1_d     = s1_q;
        s1_k_d   = s1_k_q;
        s1_vld_d = 1'b0;
        s2_d     = s2_q;
        s2_vld_d = s1_vld_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        lvl_d    = lvl_q;
        head_d   = head_q;
        vld_d    = vld_q;
        ovf_d    = ovf_q;
        sat_d    = sat_q;

        // A new frame uses the live dec_sel. Mid-frame the latched k is used.
        accept = en & in_valid;
        k_eff  = (cnt_q == 3'd0) ? dec_sel : k_q;
        last   = (cnt_q == 3'((4'd1 << k_eff) - 4'd1));
        in_sx  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
        sum    = ((cnt_q == 3'd0) ? ACC_W'(0) : acc_q) + in_sx;

        if (!en) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            acc_d = sum;
            if (cnt_q == 3'd0) begin
                k_d = dec_sel;
            end
            cnt_d = last ? 3'd0 : cnt_q + 3'd1;
            if (last) begin
                s1_d     = sum;
                s1_k_d   = k_eff;
                s1_vld_d = 1'b1;
            end
        end

        // Average by shifting with round-half-up, then clamp to OUT_W
        n       = N_W'(s1_k_q) + N_W'(SHIFT);
        rnd_add = (n == '0) ? '0 : (RND_W'(1) << (n - N_W'(1)));
        rnd     = {s1_q[ACC_W-1], s1_q} + rnd_add;
        shifted = rnd >>> n;
        clip_hi = shifted > SAT_MAX;
        clip_lo = shifted < SAT_MIN;
        sat_val = clip_hi ? SAT_MAX[OUT_W-1:0] :
                  clip_lo ? SAT_MIN[OUT_W-1:0] : shifted[OUT_W-1:0];
        if (s1_vld_q) begin
            s2_d = sat_val;
        end

        // FIFO. A push into a full FIFO is still legal when a pop happens in the same cycle.
        pop     = vld_q & out_ready;
        full    = (lvl_q == LVL_W'(FIFO_DEPTH));
        push_ok = s2_vld_q & (~full | pop);
        drop    = s2_vld_q & full & ~pop;
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (push_ok) begin
            wr_d = wr_q + PTR_W'(1);
        end
        lvl_d = lvl_q + LVL_W'(push_ok) - LVL_W'(pop);
        vld_d = (lvl_d != '0);

        // Registered head. If the FIFO empties, the last value is kept.
        if (lvl_d != '0) begin
            if ((lvl_q - LVL_W'(pop)) == '0) begin
                head_d = s2_q;
            end else begin
                head_d = mem_q[rd_d];
            end
        end

        ovf_d = (ovf_q & ~clr_flags) | drop;
        sat_d = (sat_q & ~clr_flags) | (s1_vld_q & (clip_hi | clip_lo));
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            s1_q     <= '0;
            s1_k_q   <= '0;
            s1_vld_q <= 1'b0;
            s2_q     <= '0;
            s2_vld_q <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            lvl_q    <= '0;
            head_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            s1_q     <= s1_d;
            s1_k_q   <= s1_k_d;
            s1_vld_q <= s1_vld_d;
            s2_q     <= s2_d;
            s2_vld_q <= s2_vld_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            lvl_q    <= lvl_d;
            head_q   <= head_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            sat_q    <= sat_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_q] <= s2_q;
        end
    end

    assign out_data   = head_q;
    assign out_valid  = vld_q;
    assign ovf        = ovf_q;
    assign sat        = sat_q;
    assign fifo_level = lvl_q;

endmodule
